// File: rtl/sketch_sram_update.sv
// sketch_sram_update
// Count-sketch SRAM updater. Hash indices and packet lengths arrive on two
// independent strobe streams and queue in separate FIFOs. Pairs are popped in
// arrival order. Each pair triggers a read-modify-write of one SRAM word:
// [DATA_WIDTH-1:12] is a saturating byte count and [11:0] is a saturating
// packet count. A clear request zeroes the whole SRAM, one word per accepted
// write.
//
// Ports
//   memclk, reset         clock, synchronous active-high reset
//   id_valid/id_in        hash index strobe and value
//   byte_valid/byte_in    packet length strobe and value
//   clear_start           request to zero every SRAM word
//   sram_rd_*             read request/address, read data/valid
//   sram_wr_*             write request/address/data
//   sram_ready            controller accepts the asserted request
//   busy                  FSM not idle
//   update_cnt            completed updates (wraps)
//   drop_cnt              strobes lost to a full FIFO (saturates)
//   timeout_cnt           reads aborted for lack of data (saturates)

// Small first-word-fall-through FIFO; a push while full is discarded.
module sketch_sram_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         memclk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge memclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge memclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module sketch_sram_update #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 36,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 63
) (
    input  logic                  memclk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [15:0]           id_in,
    input  logic                  byte_valid,
    input  logic [15:0]           byte_in,
    input  logic                  clear_start,
    output logic                  sram_rd_req,
    output logic [ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic [DATA_WIDTH-1:0] sram_rd_data,
    input  logic                  sram_rd_valid,
    output logic                  sram_wr_req,
    output logic [ADDR_WIDTH-1:0] sram_wr_addr,
    output logic [DATA_WIDTH-1:0] sram_wr_data,
    input  logic                  sram_ready,
    output logic                  busy,
    output logic [31:0]           update_cnt,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           timeout_cnt
);
    localparam int BW = DATA_WIDTH - 12;        // byte-count field width
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, CLEAR} state_t;

    state_t state, state_n;

    // ---------------- input FIFOs ----------------
    logic [15:0] id_dout, len_dout;
    logic        id_empty, id_full, len_empty, len_full;
    logic        pop;

    sketch_sram_fifo #(.W(16), .DEPTH(FIFO_DEPTH)) u_id_fifo (
        .memclk (memclk),
        .reset  (reset),
        .push   (id_valid),
        .din    (id_in),
        .pop    (pop),
        .dout   (id_dout),
        .empty  (id_empty),
        .full   (id_full)
    );

    sketch_sram_fifo #(.W(16), .DEPTH(FIFO_DEPTH)) u_len_fifo (
        .memclk (memclk),
        .reset  (reset),
        .push   (byte_valid),
        .din    (byte_in),
        .pop    (pop),
        .dout   (len_dout),
        .empty  (len_empty),
        .full   (len_full)
    );

    // ---------------- drop counter ----------------
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    assign drop_inc = {1'b0, id_valid & id_full} + {1'b0, byte_valid & len_full};
    assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};

    always_ff @(posedge memclk) begin
        if (reset)
            drop_cnt <= '0;
        else
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // ---------------- update arithmetic ----------------
    logic [BW:0]           byte_sum;
    logic [BW-1:0]         new_bytes;
    logic [11:0]           new_pkts;
    logic [DATA_WIDTH-1:0] new_word;
    logic [15:0]           len_q, len_n;

    always_comb begin
        byte_sum  = {1'b0, sram_rd_data[DATA_WIDTH-1:12]} + (BW+1)'(len_q);
        new_bytes = byte_sum[BW] ? {BW{1'b1}} : byte_sum[BW-1:0];
        new_pkts  = (sram_rd_data[11:0] == 12'hFFF) ? 12'hFFF
                                                    : sram_rd_data[11:0] + 12'd1;
        new_word  = {new_bytes, new_pkts};
    end

    // ---------------- FSM ----------------
    // Every output has a *_n shadow computed here and registered below, so
    // all outputs come straight from flops.
    logic                  clear_pending, clear_pending_n;
    logic [TW-1:0]         timer, timer_n;
    logic                  rd_req_n, wr_req_n, busy_n;
    logic [ADDR_WIDTH-1:0] rd_addr_n, wr_addr_n;
    logic [DATA_WIDTH-1:0] wr_data_n;
    logic [31:0]           update_cnt_n;
    logic [15:0]           timeout_cnt_n;

    always_comb begin
        state_n       = state;
        pop           = 1'b0;
        len_n         = len_q;
        timer_n       = timer;
        rd_req_n      = sram_rd_req;
        rd_addr_n     = sram_rd_addr;
        wr_req_n      = sram_wr_req;
        wr_addr_n     = sram_wr_addr;
        wr_data_n     = sram_wr_data;
        update_cnt_n  = update_cnt;
        timeout_cnt_n = timeout_cnt;
        // Pulses arriving while already clearing are merged into that clear.
        clear_pending_n = clear_pending | (clear_start && state != CLEAR);

        case (state)
            IDLE: begin
                if (clear_pending) begin
                    state_n   = CLEAR;
                    wr_req_n  = 1'b1;
                    wr_addr_n = '0;
                    wr_data_n = '0;
                end else if (!id_empty && !len_empty) begin
                    pop       = 1'b1;
                    len_n     = len_dout;
                    rd_addr_n = id_dout[ADDR_WIDTH-1:0];
                    rd_req_n  = 1'b1;
                    state_n   = RD_REQ;
                end
            end
            RD_REQ: begin
                if (sram_ready) begin
                    rd_req_n = 1'b0;
                    timer_n  = '0;
                    state_n  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (sram_rd_valid) begin
                    wr_req_n  = 1'b1;
                    wr_addr_n = sram_rd_addr;
                    wr_data_n = new_word;
                    state_n   = WR_REQ;
                end else if (timer == TIMER_LAST) begin
                    // Abort: the job is dropped, nothing is written back.
                    timer_n       = '0;
                    timeout_cnt_n = (timeout_cnt == 16'hFFFF) ? timeout_cnt
                                                              : timeout_cnt + 16'd1;
                    state_n       = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            WR_REQ: begin
                if (sram_ready) begin
                    wr_req_n     = 1'b0;
                    update_cnt_n = update_cnt + 32'd1;
                    state_n      = IDLE;
                end
            end
            CLEAR: begin
                if (sram_ready) begin
                    if (sram_wr_addr == {ADDR_WIDTH{1'b1}}) begin
                        wr_req_n        = 1'b0;
                        clear_pending_n = 1'b0;
                        state_n         = IDLE;
                    end else begin
                        wr_addr_n = sram_wr_addr + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge memclk) begin
        if (reset) begin
            state         <= IDLE;
            len_q         <= '0;
            timer         <= '0;
            clear_pending <= 1'b0;
            sram_rd_req   <= 1'b0;
            sram_rd_addr  <= '0;
            sram_wr_req   <= 1'b0;
            sram_wr_addr  <= '0;
            sram_wr_data  <= '0;
            busy          <= 1'b0;
            update_cnt    <= '0;
            timeout_cnt   <= '0;
        end else begin
            state         <= state_n;
            len_q         <= len_n;
            timer         <= timer_n;
            clear_pending <= clear_pending_n;
            sram_rd_req   <= rd_req_n;
            sram_rd_addr  <= rd_addr_n;
            sram_wr_req   <= wr_req_n;
            sram_wr_addr  <= wr_addr_n;
            sram_wr_data  <= wr_data_n;
            busy          <= busy_n;
            update_cnt    <= update_cnt_n;
            timeout_cnt   <= timeout_cnt_n;
        end
    end
endmodule

// File: tb/tb_sketch_sram_update.sv
// Directed testbench for sketch_sram_update. The bench plays the SRAM
// controller by hand: it drives sram_ready and returns read data, and checks
// addresses, data, latency, counters and the clear sweep against
// hand-computed values.
module tb_sketch_sram_update;
    logic        memclk;
    logic        reset;
    logic        id_valid;
    logic [15:0] id_in;
    logic        byte_valid;
    logic [15:0] byte_in;
    logic        clear_start;
    logic        sram_rd_req;
    logic [15:0] sram_rd_addr;
    logic [35:0] sram_rd_data;
    logic        sram_rd_valid;
    logic        sram_wr_req;
    logic [15:0] sram_wr_addr;
    logic [35:0] sram_wr_data;
    logic        sram_ready;
    logic        busy;
    logic [31:0] update_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] timeout_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    sketch_sram_update dut (
        .memclk        (memclk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_in         (id_in),
        .byte_valid    (byte_valid),
        .byte_in       (byte_in),
        .clear_start   (clear_start),
        .sram_rd_req   (sram_rd_req),
        .sram_rd_addr  (sram_rd_addr),
        .sram_rd_data  (sram_rd_data),
        .sram_rd_valid (sram_rd_valid),
        .sram_wr_req   (sram_wr_req),
        .sram_wr_addr  (sram_wr_addr),
        .sram_wr_data  (sram_wr_data),
        .sram_ready    (sram_ready),
        .busy          (busy),
        .update_cnt    (update_cnt),
        .drop_cnt      (drop_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    initial memclk = 1'b0;
    always #5 memclk = ~memclk;

    task automatic tick();
        @(posedge memclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pair(input logic [15:0] id, input logic [15:0] len);
        id_valid   = 1'b1;
        id_in      = id;
        byte_valid = 1'b1;
        byte_in    = len;
        tick();
        id_valid   = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic wait_rd(input string tag);
        int n = 0;
        while (!sram_rd_req && n < 50) begin
            tick();
            n++;
        end
        check(tag, 64'(sram_rd_req), 64'd1);
    endtask

    // One full read-modify-write with sram_ready held high.
    task automatic job(input string tag, input logic [15:0] exp_addr,
                       input logic [35:0] old_word, input logic [35:0] exp_data);
        wait_rd({tag, "_rdreq"});
        check({tag, "_rdaddr"}, 64'(sram_rd_addr), 64'(exp_addr));
        tick();
        check({tag, "_rd_drop"}, 64'(sram_rd_req), 64'd0);
        sram_rd_valid = 1'b1;
        sram_rd_data  = old_word;
        tick();
        sram_rd_valid = 1'b0;
        check({tag, "_wrreq"}, 64'({sram_wr_req, sram_rd_req}), 64'b10);
        check({tag, "_wraddr"}, 64'(sram_wr_addr), 64'(exp_addr));
        check({tag, "_wrdata"}, 64'(sram_wr_data), 64'(exp_data));
        tick();
        check({tag, "_wr_drop"}, 64'(sram_wr_req), 64'd0);
    endtask

    initial begin
        int          cnt;
        int          bad;
        int          exp_a;
        logic        saw_wr;
        logic [35:0] ed;

        reset         = 1'b1;
        id_valid      = 1'b0;
        id_in         = '0;
        byte_valid    = 1'b0;
        byte_in       = '0;
        clear_start   = 1'b0;
        sram_rd_data  = '0;
        sram_rd_valid = 1'b0;
        sram_ready    = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // ---- reset state ----
        check("rst_reqs", 64'({sram_rd_req, sram_wr_req, busy}), 64'd0);
        check("rst_upd", 64'(update_cnt), 64'd0);
        check("rst_cnts", 64'({drop_cnt, timeout_cnt}), 64'd0);

        // ---- basic update with latency: push edge, then pop edge ----
        push_pair(16'h0005, 16'd64);
        check("lat_not_yet", 64'({sram_rd_req, busy}), 64'd0);
        tick();
        check("lat_rdreq", 64'({sram_rd_req, busy}), 64'b11);
        job("basic", 16'h0005, 36'h0, {24'd64, 12'd1});
        check("basic_upd", 64'(update_cnt), 64'd1);

        // ---- saturation: both fields, then packet field only ----
        push_pair(16'h0123, 16'd100);
        job("sat_both", 16'h0123, {24'hFFFFF0, 12'hFFF}, {24'hFFFFFF, 12'hFFF});
        push_pair(16'hFFFF, 16'h0010);
        job("sat_pkt", 16'hFFFF, {24'h000100, 12'hFFE}, {24'h000110, 12'hFFF});
        check("sat_upd", 64'(update_cnt), 64'd3);

        // ---- 9 ids with no lengths: one dropped, then 8 ordered jobs ----
        for (int i = 0; i < 9; i++) begin
            id_valid = 1'b1;
            id_in    = 16'h0010 + 16'(i);
            tick();
        end
        id_valid = 1'b0;
        check("q_drop", 64'(drop_cnt), 64'd1);
        check("q_idle", 64'({busy, sram_rd_req}), 64'd0);
        sram_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1;
            byte_in    = 16'(i + 1);
            tick();
        end
        byte_valid = 1'b0;
        check("q_stall_rd", 64'({sram_rd_req, sram_rd_addr}), 64'h1_0010);
        sram_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ed = {24'(i + 1), 12'd1};
            job($sformatf("q%0d", i), 16'h0010 + 16'(i), 36'h0, ed);
        end
        check("q_upd", 64'(update_cnt), 64'd11);
        check("q_drop_final", 64'(drop_cnt), 64'd1);

        // ---- read timeout ----
        push_pair(16'h0042, 16'd10);
        wait_rd("to_rdreq");
        check("to_rdaddr", 64'(sram_rd_addr), 64'h42);
        tick();
        cnt    = 0;
        saw_wr = 1'b0;
        while (busy && cnt < 200) begin
            tick();
            cnt++;
            if (sram_wr_req) saw_wr = 1'b1;
        end
        check("to_cycles", 64'(cnt), 64'd63);
        check("to_cnt", 64'(timeout_cnt), 64'd1);
        check("to_no_wr", 64'(saw_wr), 64'd0);
        sram_rd_valid = 1'b1;
        sram_rd_data  = 36'h0;
        tick();
        sram_rd_valid = 1'b0;
        tick();
        tick();
        check("late_valid", 64'({busy, sram_wr_req, sram_rd_req}), 64'd0);
        check("late_upd", 64'(update_cnt), 64'd11);

        // ---- clear requested during WR_REQ ----
        push_pair(16'h0007, 16'd1);
        wait_rd("clr_rdreq");
        tick();
        sram_rd_valid = 1'b1;
        sram_rd_data  = 36'h0;
        tick();
        sram_rd_valid = 1'b0;
        check("clr_job_wr", 64'({sram_wr_req, sram_wr_addr}), 64'h1_0007);
        check("clr_job_data", 64'(sram_wr_data), 64'({24'd1, 12'd1}));
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        check("clr_job_upd", 64'(update_cnt), 64'd12);
        exp_a = 0;
        bad   = 0;
        cnt   = 0;
        while (cnt < 70000) begin
            clear_start = (exp_a == 1000);
            if (sram_wr_req) begin
                if (sram_wr_addr != 16'(exp_a) || sram_wr_data != 36'h0) bad++;
                exp_a++;
            end else if (exp_a > 0) begin
                break;
            end
            tick();
            cnt++;
        end
        clear_start = 1'b0;
        check("clr_count", 64'(exp_a), 64'd65536);
        check("clr_bad", 64'(bad), 64'd0);
        check("clr_done", 64'({busy, sram_wr_req}), 64'd0);
        tick();
        tick();
        check("clr_merged", 64'({busy, sram_wr_req}), 64'd0);
        check("clr_upd", 64'(update_cnt), 64'd12);

        // ---- stall in RD_REQ, then reset mid-job ----
        push_pair(16'h0033, 16'd5);
        sram_ready = 1'b0;
        wait_rd("rs_rdreq");
        repeat (5) tick();
        check("rs_stall", 64'({sram_rd_req, sram_rd_addr}), 64'h1_0033);
        sram_ready = 1'b1;
        tick();
        check("rs_wait", 64'({busy, sram_rd_req}), 64'b10);
        push_pair(16'h0044, 16'd9);
        reset = 1'b1;
        tick();
        check("rs_out", 64'({sram_rd_req, sram_wr_req, busy, sram_rd_addr, sram_wr_addr}), 64'd0);
        check("rs_data", 64'(sram_wr_data), 64'd0);
        check("rs_cnts", 64'({update_cnt, drop_cnt, timeout_cnt}), 64'd0);
        reset = 1'b0;
        sram_rd_valid = 1'b1;
        tick();
        sram_rd_valid = 1'b0;
        check("rs_after", 64'({sram_rd_req, sram_wr_req, busy}), 64'd0);
        saw_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (sram_rd_req || sram_wr_req || busy) saw_wr = 1'b1;
        end
        check("rs_fifo_empty", 64'(saw_wr), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sketch_sram_update.md
SKETCH_SRAM_UPDATE -- requirements
Module: sketch_sram_update

Interface
REQ-001 Parameter ADDR_WIDTH, 16, SRAM word address width.
REQ-002 Parameter DATA_WIDTH, 36, SRAM word width: [35:12] byte counter, [11:0] packet counter.
REQ-003 Parameter FIFO_DEPTH, 8, entries per input FIFO, power of 2.
REQ-004 Parameter TIMEOUT, 63, max cycles in RD_WAIT before abort.
REQ-005 memclk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 id_valid  input  1  one-cycle strobe, hash index valid (universal-hash stage din_inc).
REQ-008 id_in  input  16  hash index (SRAM_ID from universal-hash stage).
REQ-009 byte_valid  input  1  one-cycle strobe, packet length valid.
REQ-010 byte_in  input  16  packet length in bytes.
REQ-011 clear_start  input  1  pulse, request zeroing of all SRAM words.
REQ-012 sram_rd_req  output  1  read request, held until sram_ready.
REQ-013 sram_rd_addr  output  ADDR_WIDTH  read address.
REQ-014 sram_rd_data  input  DATA_WIDTH  read data.
REQ-015 sram_rd_valid  input  1  read data valid.
REQ-016 sram_wr_req  output  1  write request, held until sram_ready.
REQ-017 sram_wr_addr  output  ADDR_WIDTH  write address.
REQ-018 sram_wr_data  output  DATA_WIDTH  write data.
REQ-019 sram_ready  input  1  controller accepts the asserted request this cycle.
REQ-020 busy  output  1  state != IDLE.
REQ-021 update_cnt  output  32  completed updates, wraps.
REQ-022 drop_cnt  output  16  strobes lost to full FIFO, saturates at 0xFFFF.
REQ-023 timeout_cnt  output  16  aborted reads, saturates at 0xFFFF.

Function
REQ-024 Two FIFOs (ID, length): entry written on strobe when not full; strobe while full is dropped, drop_cnt +1 per dropped strobe (+2 if both same cycle).
REQ-025 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, CLEAR; all outputs registered.
REQ-026 IDLE: pending clear has priority -> CLEAR; else if both FIFOs non-empty, pop both same cycle, latch addr = id[ADDR_WIDTH-1:0] and len -> RD_REQ.
REQ-027 RD_REQ: sram_rd_req=1, sram_rd_addr=addr stable; on sram_ready -> RD_WAIT, rd_req deasserted next cycle.
REQ-028 RD_WAIT: on sram_rd_valid compute word -> WR_REQ; timer counts from entry; at TIMEOUT cycles without valid -> IDLE, job discarded, timeout_cnt +1.
REQ-029 sram_rd_valid outside RD_WAIT is ignored.
REQ-030 Update arithmetic: byte field = min(old+len, 2^24-1); packet field = min(old+1, 4095); both saturate independently.
REQ-031 WR_REQ: sram_wr_req=1, wr_addr=addr, wr_data=new word stable; on sram_ready update_cnt +1 -> IDLE.
REQ-032 sram_rd_req and sram_wr_req never asserted together; one job outstanding at a time (no RAW hazard).
REQ-033 Latency with sram_ready=1: pop at edge k -> rd_req high cycle k+1; rd_valid at cycle m -> wr_req high cycle m+1.
REQ-034 clear_start in any state sets clear_pending; taken at next IDLE; repeated pulses while pending/clearing merge.
REQ-035 CLEAR: write 0 to addresses 0..2^ADDR_WIDTH-1 ascending, one per sram_ready cycle; after last address clear_pending=0 -> IDLE.
REQ-036 FIFOs keep accepting strobes during all non-IDLE states.
REQ-037 FIFO unequal occupancy permitted; pairing strictly in arrival order.

Reset
REQ-038 On reset: state IDLE, FIFOs empty, clear_pending 0, timer 0, all outputs and counters 0.
REQ-039 Reset mid-job abandons it; no read/write request asserted the cycle after reset is released.

Verification
REQ-040 id 0x0005 + len 64, SRAM word 0 -> write addr 5 data {24'd64,12'd1}; update_cnt=1.
REQ-041 Old word {24'hFFFFF0,12'hFFF}, len 100 -> write {24'hFFFFFF,12'hFFF}.
REQ-042 9 id strobes, no length, while stalled -> 8 queued, drop_cnt=1; then 8 lengths -> 8 writes in order.
REQ-043 rd_req accepted, no rd_valid for 63 cycles -> IDLE, timeout_cnt=1, no write; late rd_valid ignored.
REQ-044 clear_start during WR_REQ -> job completes, then 65536 zero writes 0..0xFFFF, busy low after last.
REQ-045 sram_ready low 5 cycles in RD_REQ, then reset asserted in RD_WAIT -> all outputs 0, FIFOs empty, no write issued.
